hazard_unit: RTL
================

// Module: hazard_unit
// PURPOSE
//  Pipeline hazard/control unit for the 5-stage MIPS core. Sits beside the datapath.
//  Consumes the stage register numbers and write-enables that the datapath exports.
//  Produces: forwarding selects (DFasel/DFbsel); IF/ID Flush; PC/IF-ID stall; ID/EX bubble.
//  Also runs a wait FSM for a variable-latency data memory, plus stall/flush perf counters.
// PARAMETERS
//  MAX_WAIT  15  max consecutive cycles in WAIT with dmem_ready=0 before entering ERR
//  CNT_W     32  width of stall_count / flush_count
// PORTS
//  clk            in   1      core clock; all state updates on posedge
//  rst            in   1      synchronous, active-high reset
//  id_rs,id_rt    in   5      source registers of the instruction in ID (IF/ID register)
//  id_uses_rt     in   1      ID instruction reads rt (R-type, beq, sw)
//  id_branch      in   1      ID instruction is a conditional branch (compares in ID)
//  id_jr          in   1      ID instruction is jr (reads rs in ID)
//  br_taken       in   1      Branch & Zero, or jump, or jr, resolved in ID this cycle
//  ex_rs,ex_rt    in   5      Rs_lv2 / Rt_lv2
//  ex_writereg    in   5      destination register computed in EX
//  ex_regwrite    in   1      RegWrite of the EX instruction
//  ex_memread     in   1      MemRead of the EX instruction
//  mem_writereg   in   5      OWriteReg_lv3
//  mem_regwrite   in   1      ORegWrite_lv3
//  mem_memread    in   1      MemRead of the MEM instruction
//  mem_access     in   1      MEM stage does a load or a store this cycle
//  dmem_ready     in   1      data memory completes the current access this cycle
//  wb_writereg    in   5      OWriteReg_lv4
//  wb_regwrite    in   1      ORegWrite_lv4
//  DFasel,DFbsel  out  2      00 regfile, 01 MEM aluout, 10 WB data, 11 never driven
//  pc_write       out  1      PC register load enable
//  ifid_write     out  1      IF/ID register load enable
//  idex_bubble    out  1      zero the ID/EX control bits (insert a nop)
//  Flush          out  1      clear the IF/ID register at the next edge
//  freeze         out  1      hold every pipeline register (memory wait)
//  err            out  1      sticky memory-timeout flag
//  stall_count    out  CNT_W  cycles in which pc_write=0
//  flush_count    out  CNT_W  cycles in which Flush=1
// BEHAVIOUR
//  Reset: state=RUN, wait_cnt=0, err=0, both counters=0.
//   Combinational outputs after reset: DF*=00, pc_write=1, ifid_write=1, others 0.
//  Forwarding (combinational; same rule for rs->DFasel and rt->DFbsel):
//   01 if mem_regwrite && mem_writereg!=0 && mem_writereg==ex_rX.
//   Else 10 if wb_regwrite && wb_writereg!=0 && wb_writereg==ex_rX.
//   Else 00. MEM match takes priority over WB match.
//  Load-use stall (LU): ex_memread && ex_writereg!=0 &&
//   (ex_writereg==id_rs || (id_uses_rt && ex_writereg==id_rt)).
//  Branch-operand stall (BS): (id_branch||id_jr) && the ID source register is nonzero and either
//   (a) ex_regwrite && ex_writereg matches, or
//   (b) mem_memread && mem_writereg matches.
//  In RUN with LU|BS: pc_write=0, ifid_write=0, idex_bubble=1, Flush=0.
//   The stall lasts as long as the condition holds (1 cycle for LU, 1-2 cycles for BS).
//  In RUN with br_taken && !(LU|BS): Flush=1 for that cycle. The fall-through fetch is discarded.
//  FSM states RUN, WAIT, ERR:
//   RUN -> WAIT when mem_access && !dmem_ready.
//   WAIT -> RUN on dmem_ready.
//   WAIT -> ERR when wait_cnt reaches MAX_WAIT.
//   ERR -> RUN only on rst.
//  Mem-wait stall and ordering:
//   The mem-wait stall is seen combinationally in the first cycle (RUN && mem_access && !dmem_ready).
//   While WAIT/ERR, or in that first cycle: freeze=1, pc_write=0, ifid_write=0, idex_bubble=0, Flush=0.
//   Freeze has priority over LU/BS/Flush. The hazard is re-evaluated on the cycle freeze drops.
//  wait_cnt: increments each WAIT cycle; cleared on entry to RUN.
//  err: set on entry to ERR; held until rst.
//  Counters:
//   stall_count increments on each cycle with pc_write=0, including freeze cycles.
//   flush_count increments on each cycle with Flush=1.
//   Both wrap modulo 2^CNT_W.
//  Simultaneous events:
//   rst wins over everything.
//   br_taken during LU/BS is ignored; the branch resolves again after the stall.
// STRUCTURE
//  Shared package core_pkg holds:
//   FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10;
//   the hz_state_t encoding RUN=0, WAIT=1, ERR=2.
//  One sub-module: fwd_sel (pure combinational); instantiate it twice, for rs and rt.
//  FSM, stall logic and counters are in the top level.
// TESTING
//  1. add r3 in MEM, EX reads rs=3, WB also writes r3 -> DFasel=01 (MEM wins); wb only -> 10.
//  2. lw r5 in EX; ID add reads r5 -> one cycle of pc_write=0, idex_bubble=1; then DFasel=10; stall_count=1.
//  3. beq in ID, br_taken=1, no hazard -> Flush=1 for one cycle; flush_count=1; pc_write=1.
//  4. beq reads r4 while lw r4 is in EX -> 2 stall cycles, then Flush=1 once br_taken.
//  5. sw in MEM, dmem_ready low 3 cycles -> freeze=1 for 3 cycles, state back to RUN, stall_count=3.
//  6. dmem_ready held 0 with MAX_WAIT=15 -> ERR, err=1 sticky; rst -> err=0, counters=0, state RUN.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared forwarding codes, hazard FSM states and register-match helper
package core_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } hz_state_t;

    // True when a writing stage targets a real (nonzero) register equal to the reader's source
    function automatic logic reg_match(input logic we, input logic [4:0] wr, input logic [4:0] rr);
        return we && (wr != 5'd0) && (wr == rr);
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - datapath <-> hazard unit signal bundle
interface hazard_unit_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_branch;
    logic             id_jr;
    logic             br_taken;
    logic [4:0]       ex_rs;
    logic [4:0]       ex_rt;
    logic [4:0]       ex_writereg;
    logic             ex_regwrite;
    logic             ex_memread;
    logic [4:0]       mem_writereg;
    logic             mem_regwrite;
    logic             mem_memread;
    logic             mem_access;
    logic             dmem_ready;
    logic [4:0]       wb_writereg;
    logic             wb_regwrite;
    logic [1:0]       DFasel;
    logic [1:0]       DFbsel;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_bubble;
    logic             Flush;
    logic             freeze;
    logic             err;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_branch, id_jr, br_taken,
               ex_rs, ex_rt, ex_writereg, ex_regwrite, ex_memread,
               mem_writereg, mem_regwrite, mem_memread, mem_access, dmem_ready,
               wb_writereg, wb_regwrite,
        input  DFasel, DFbsel, pc_write, ifid_write, idex_bubble, Flush,
               freeze, err, stall_count, flush_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_branch, id_jr, br_taken,
               ex_rs, ex_rt, ex_writereg, ex_regwrite, ex_memread,
               mem_writereg, mem_regwrite, mem_memread, mem_access, dmem_ready,
               wb_writereg, wb_regwrite,
        output DFasel, DFbsel, pc_write, ifid_write, idex_bubble, Flush,
               freeze, err, stall_count, flush_count
    );
endinterface

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - ALU operand forwarding select for one EX source register
module fwd_sel
    import core_pkg::*;
(
    input  logic [4:0] ex_r,
    input  logic [4:0] mem_writereg,
    input  logic       mem_regwrite,
    input  logic [4:0] wb_writereg,
    input  logic       wb_regwrite,
    output logic [1:0] sel
);

    // The MEM stage holds the younger result, so it wins over WB
    always_comb begin
        sel = FWD_REG;
        if (reg_match(mem_regwrite, mem_writereg, ex_r))
            sel = FWD_MEM;
        else if (reg_match(wb_regwrite, wb_writereg, ex_r))
            sel = FWD_WB;
    end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - forwarding, stall/flush control, memory-wait FSM and perf counters
module hazard_unit
    import core_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic         clk,
    input  logic         rst,
    hazard_unit_if.slave hz
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WC_LAST = WAIT_W'(MAX_WAIT - 1);

    hz_state_t         state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              err_q;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    logic lu, bs, hazard, freeze_c;
    logic pc_write_c, ifid_write_c, idex_bubble_c, flush_c;
    logic rs_busy, rt_busy;

    fwd_sel u_fwd_a (
        .ex_r         (hz.ex_rs),
        .mem_writereg (hz.mem_writereg),
        .mem_regwrite (hz.mem_regwrite),
        .wb_writereg  (hz.wb_writereg),
        .wb_regwrite  (hz.wb_regwrite),
        .sel          (hz.DFasel)
    );

    fwd_sel u_fwd_b (
        .ex_r         (hz.ex_rt),
        .mem_writereg (hz.mem_writereg),
        .mem_regwrite (hz.mem_regwrite),
        .wb_writereg  (hz.wb_writereg),
        .wb_regwrite  (hz.wb_regwrite),
        .sel          (hz.DFbsel)
    );

    // Branch compares in ID need the value ready; an ALU result in EX or a load in MEM is not
    always_comb begin
        lu = hz.ex_memread && (hz.ex_writereg != 5'd0) &&
             ((hz.ex_writereg == hz.id_rs) || (hz.id_uses_rt && (hz.ex_writereg == hz.id_rt)));
        rs_busy = reg_match(hz.ex_regwrite, hz.ex_writereg, hz.id_rs) ||
                  reg_match(hz.mem_memread, hz.mem_writereg, hz.id_rs);
        rt_busy = reg_match(hz.ex_regwrite, hz.ex_writereg, hz.id_rt) ||
                  reg_match(hz.mem_memread, hz.mem_writereg, hz.id_rt);
        bs = ((hz.id_branch || hz.id_jr) && rs_busy) || (hz.id_branch && rt_busy);
        hazard = lu || bs;
    end

    // The cycle dmem_ready arrives in WAIT the access completes, so the pipeline may advance then
    always_comb begin
        freeze_c = (state == ERR) ||
                   ((state == WAIT) && !hz.dmem_ready) ||
                   ((state == RUN) && hz.mem_access && !hz.dmem_ready);
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        idex_bubble_c = 1'b0;
        flush_c       = 1'b0;
        if (freeze_c) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
        end else if (hazard) begin
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            idex_bubble_c = 1'b1;
        end else if (hz.br_taken) begin
            flush_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            err_q     <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    wait_cnt <= '0;
                    if (hz.mem_access && !hz.dmem_ready)
                        state <= WAIT;
                end
                WAIT: begin
                    if (hz.dmem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == WC_LAST) begin
                            state <= ERR;
                            err_q <= 1'b1;
                        end
                    end
                end
                ERR: begin
                    err_q <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
            if (!pc_write_c)
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_c)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign hz.pc_write    = pc_write_c;
    assign hz.ifid_write  = ifid_write_c;
    assign hz.idex_bubble = idex_bubble_c;
    assign hz.Flush       = flush_c;
    assign hz.freeze      = freeze_c;
    assign hz.err         = err_q;
    assign hz.stall_count = stall_cnt;
    assign hz.flush_count = flush_cnt;

endmodule
